// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: boot loader that packs a byte stream into 32-bit words, writes them
// into the instruction memory, then hands the memory read port to the CPU fetch path.
module imem_loader_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [31:0]       inst,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_rd
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              len_ok, last_word, idle;
  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    err_d      = 1'b0;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    len_ok     = (len != '0) && (len <= (ADDR_W+1)'(DEPTH));
    last_word  = word_cnt_q == len_q - (ADDR_W+1)'(1);
    case (state_q)
      IDLE: if (start) begin
        if (len_ok) begin
          state_d    = LOAD;
          len_d      = len;
          word_cnt_d = '0;
          byte_cnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      LOAD: if (in_valid) begin
        shreg_d    = {shreg_q[23:0], in_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = (byte_cnt_q == 2'd3) ? WRITE : LOAD;
      end
      WRITE: begin
        state_d    = last_word ? DONE : LOAD;
        word_cnt_d = last_word ? word_cnt_q : word_cnt_q + (ADDR_W+1)'(1);
        byte_cnt_d = '0;
      end
      default: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
    end
  end
  // Outputs decode the registered state only, so they are glitch-free w.r.t. inputs
  // except the CPU read path, which must stay combinational for same-cycle fetch.
  assign idle         = state_q == IDLE;
  assign in_ready     = state_q == LOAD;
  assign busy         = !idle;
  assign done         = state_q == DONE;
  assign err          = err_q;
  assign cpu_stall    = busy | ~loaded_q;
  assign mem_memwrite = state_q == WRITE;
  assign mem_memread  = idle;
  assign mem_addr     = idle ? pc_addr : word_cnt_q[ADDR_W-1:0];
  assign mem_wd       = shreg_q;
  assign inst         = (idle && loaded_q) ? mem_rd : 32'd0;
endmodule
